uart_tx_buffer: RTL

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO between CPU stores and a UART transmitter, drained by a start/busy handshake FSM.
// Define UART_TXBUF_DROP_COUNT_EN to add the saturating Drop_Count output.
module uart_tx_buffer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int START_TMO = 64
) (
    input  logic        clock_50MHz,
    input  logic        Reset,
    input  logic        WriteEnable,
    input  logic [31:0] Data_In,
    input  logic        Tx_Busy,
    output logic        Tx_Start,
    output logic [7:0]  Tx_Data,
    output logic        Full,
    output logic        Empty,
    output logic [AW:0] Level,
    output logic        Overflow,
    output logic        Tmo_Flag
`ifdef UART_TXBUF_DROP_COUNT_EN
    ,
    output logic [15:0] Drop_Count
`endif
);

    localparam int PW = AW + 1;
    localparam int CW = $clog2(START_TMO + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          push, pop, drop;
    logic          unused_data;

    assign unused_data = ^Data_In[31:8];

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign Full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign Empty = (wptr_q == rptr_q);
    assign Level = wptr_q - rptr_q;

    assign push = WriteEnable && !Full && !Reset;
    assign drop = WriteEnable &&  Full && !Reset;

    assign wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    assign rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    assign ovf_d  = ovf_q | drop;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!Empty && !Tx_Busy) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rptr_q[AW-1:0]];
                    tmo_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                // The byte is already popped; a timeout abandons it rather than retrying.
                if (Tx_Busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == CW'(START_TMO - 1)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!Tx_Busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tx_start_d = (state_d == START);
    end

    always_ff @(posedge clock_50MHz) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= Data_In[7:0];
    end

    always_ff @(posedge clock_50MHz) begin
        if (Reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            tmo_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign Tx_Start = tx_start_q;
    assign Tx_Data  = tx_data_q;
    assign Overflow = ovf_q;
    assign Tmo_Flag = tmo_q;

`ifdef UART_TXBUF_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge clock_50MHz) begin
        if (Reset) drop_cnt_q <= 16'h0000;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign Drop_Count = drop_cnt_q;
`endif

endmodule
